// File: rtl/apb_gpio_irq_pkg.sv
// gpio_irq_pkg: register map, DBCFG layout and defaults shared by the GPIO interrupt block.
package gpio_irq_pkg;
    localparam int NPINS_DEF = 16;
    localparam logic [2:0] REG_IE    = 3'd0;
    localparam logic [2:0] REG_MODE  = 3'd1;
    localparam logic [2:0] REG_POL   = 3'd2;
    localparam logic [2:0] REG_BOTH  = 3'd3;
    localparam logic [2:0] REG_PEND  = 3'd4;
    localparam logic [2:0] REG_FILT  = 3'd5;
    localparam logic [2:0] REG_DBCFG = 3'd6;
    localparam int DBCFG_DIV_LSB = 0;
    localparam int DBCFG_DIV_W   = 8;
    localparam int DBCFG_DBEN    = 8;
    typedef struct packed {
        logic       dben;
        logic [7:0] div;
    } dbcfg_t;
endpackage

// File: rtl/apb_gpio_irq_if.sv
// apb_gpio_irq_if: APB3 slave bus bundle with master/slave views.
interface apb_gpio_irq_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_gpio_irq_sync_filter.sv
// gpio_sync_filter: 2-flop pad synchronizer plus optional tick-sampled debounce producing FILT.
module gpio_sync_filter #(
    parameter int NPINS = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NPINS-1:0] gpio_i,
    input  logic             dben_i,
    input  logic [7:0]       div_i,
    input  logic             clr_i,
    output logic [NPINS-1:0] filt_o
);
    logic [NPINS-1:0] s1_q, s2_q, samp_q, samp_d, filt_q, filt_d, stable;
    logic [7:0]       cnt_q, cnt_d;
    logic             tick;
    always_comb begin
        tick   = dben_i && !clr_i && cnt_q == div_i;
        cnt_d  = (clr_i || !dben_i || tick) ? '0 : cnt_q + 8'd1;
        samp_d = clr_i ? '0 : tick ? s2_q : samp_q;
        // a pin only moves when two consecutive ticks agree on its level
        stable = ~(s2_q ^ samp_q);
        filt_d = !dben_i ? s2_q : tick ? (s2_q & stable) | (filt_q & ~stable) : filt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= '0;
            s2_q   <= '0;
            samp_q <= '0;
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= gpio_i;
            s2_q   <= s1_q;
            samp_q <= samp_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end
    assign filt_o = filt_q;
endmodule

// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB-mapped GPIO edge/level interrupt controller with sticky W1C pending flags.
module apb_gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int NPINS = NPINS_DEF
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_gpio_irq_if.slave    apb,
    input  logic [NPINS-1:0] GPIOIN,
    output logic             IRQ
);
    logic [NPINS-1:0] ie_q, ie_d, mode_q, mode_d, pol_q, pol_d, both_q, both_d, pend_q, pend_d;
    logic [NPINS-1:0] filt, filtd_q, rise, fall, set_c, w1c, wdat;
    dbcfg_t           dbcfg_q, dbcfg_d;
    logic             irq_q, irq_d, wr;
    logic [2:0]       addr;
    logic             unused_bits;
    gpio_sync_filter #(.NPINS(NPINS)) u_filt (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .gpio_i (GPIOIN),
        .dben_i (dbcfg_q.dben),
        .div_i  (dbcfg_q.div),
        .clr_i  (wr && addr == REG_DBCFG),
        .filt_o (filt)
    );
    always_comb begin
        wr      = apb.PSEL & apb.PENABLE & apb.PWRITE;
        addr    = apb.PADDR[4:2];
        wdat    = apb.PWDATA[NPINS-1:0];
        ie_d    = (wr && addr == REG_IE)   ? wdat : ie_q;
        mode_d  = (wr && addr == REG_MODE) ? wdat : mode_q;
        pol_d   = (wr && addr == REG_POL)  ? wdat : pol_q;
        both_d  = (wr && addr == REG_BOTH) ? wdat : both_q;
        dbcfg_d = (wr && addr == REG_DBCFG)
                ? dbcfg_t'{dben: apb.PWDATA[DBCFG_DBEN], div: apb.PWDATA[DBCFG_DIV_LSB +: DBCFG_DIV_W]}
                : dbcfg_q;
        rise    = filt & ~filtd_q;
        fall    = ~filt & filtd_q;
        set_c   = (mode_q & ((both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)))))
                | (~mode_q & ~(filt ^ pol_q));
        w1c     = (wr && addr == REG_PEND) ? wdat : '0;
        // a set in the same cycle overrides the clear, which also keeps held levels pending
        pend_d  = (pend_q & ~w1c) | set_c;
        irq_d   = |(pend_q & ie_q);
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ie_q    <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            both_q  <= '0;
            pend_q  <= '0;
            dbcfg_q <= '0;
            filtd_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ie_q    <= ie_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            both_q  <= both_d;
            pend_q  <= pend_d;
            dbcfg_q <= dbcfg_d;
            filtd_q <= filt;
            irq_q   <= irq_d;
        end
    end
    assign apb.PRDATA = addr == REG_IE    ? 32'(ie_q)
                      : addr == REG_MODE  ? 32'(mode_q)
                      : addr == REG_POL   ? 32'(pol_q)
                      : addr == REG_BOTH  ? 32'(both_q)
                      : addr == REG_PEND  ? 32'(pend_q)
                      : addr == REG_FILT  ? 32'(filt)
                      : addr == REG_DBCFG ? 32'(dbcfg_q)
                      : 32'h0;
    assign apb.PREADY = 1'b1;
    assign IRQ = irq_q;
    assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA[31:NPINS]};
endmodule
